// File: rtl/vd_job_scheduler.sv
// Round-robin scheduler sharing one VD_core alignment engine between NUM_REQ requesters.
// Latency: grant->core_i_valid 1 cycle; core result->rsp_valid 1 cycle; rejected job->rsp_valid 1 cycle.
// Backpressure: one job in flight; req_ready only in IDLE, core/rsp outputs held until their ready.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-low reset
//   req_valid/req_ready      per-requester job handshake (req_ready one-hot or zero, combinational)
//   req_ref/req_read         flattened 2-bit-base sequences, requester i at slice i
//   req_ref_len/req_read_len flattened LEN_W-bit lengths
//   core_i_valid/core_o_ready, core_seq_*, core_*_len   job issue to VD_core
//   core_o_valid/core_i_ready, core_score/column/row    result from VD_core
//   rsp_valid/rsp_ready, rsp_id/status/score/column/row response to requester side
//   jobs_done                completed responses (wraps), stale_cnt: discarded late results (saturates)
module vd_job_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int REF_MAX     = 400,
    parameter int READ_MAX    = 150,
    parameter int SCORE_W     = 16,
    parameter int TIMEOUT_CYC = 65535,
    localparam int LEN_W      = 9,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*2*REF_MAX-1:0]  req_ref,
    input  logic [NUM_REQ*2*READ_MAX-1:0] req_read,
    input  logic [NUM_REQ*LEN_W-1:0]      req_ref_len,
    input  logic [NUM_REQ*LEN_W-1:0]      req_read_len,
    input  logic                          core_o_ready,
    output logic                          core_i_valid,
    output logic [2*REF_MAX-1:0]          core_seq_ref,
    output logic [2*READ_MAX-1:0]         core_seq_read,
    output logic [LEN_W-1:0]              core_ref_len,
    output logic [LEN_W-1:0]              core_read_len,
    output logic                          core_i_ready,
    input  logic                          core_o_valid,
    input  logic signed [SCORE_W-1:0]     core_score,
    input  logic [LEN_W-1:0]              core_column,
    input  logic [7:0]                    core_row,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [1:0]                    rsp_status,
    output logic signed [SCORE_W-1:0]     rsp_score,
    output logic [LEN_W-1:0]              rsp_column,
    output logic [7:0]                    rsp_row,
    output logic [15:0]                   jobs_done,
    output logic [7:0]                    stale_cnt
);

    localparam int REF_BITS  = 2 * REF_MAX;
    localparam int READ_BITS = 2 * READ_MAX;
    localparam int WD_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W-1:0] REF_MAX_L  = LEN_W'(REF_MAX);
    localparam logic [LEN_W-1:0] READ_MAX_L = LEN_W'(READ_MAX);

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_LEN_ERR = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [WD_W-1:0] wdog;

    // ------------------------------------------------------------------
    // Round-robin grant: first valid requester at or after rr_ptr.
    // ------------------------------------------------------------------
    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] scan_id;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_vld && req_valid[scan_id]) begin
                grant_vld = 1'b1;
                grant_id  = scan_id;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Pointer moves past the winner so it has lowest priority next round.
    logic [ID_W-1:0] ptr_next;
    assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // ------------------------------------------------------------------
    // Winner's job fields, selected from the flattened request buses.
    // ------------------------------------------------------------------
    logic [REF_BITS-1:0]  sel_ref;
    logic [READ_BITS-1:0] sel_read;
    logic [LEN_W-1:0]     sel_ref_len;
    logic [LEN_W-1:0]     sel_read_len;

    always_comb begin
        sel_ref      = '0;
        sel_read     = '0;
        sel_ref_len  = '0;
        sel_read_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_ref      = req_ref[i*REF_BITS +: REF_BITS];
                sel_read     = req_read[i*READ_BITS +: READ_BITS];
                sel_ref_len  = req_ref_len[i*LEN_W +: LEN_W];
                sel_read_len = req_read_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // A job the core could not legally align is answered locally.
    logic len_ok;
    assign len_ok = (sel_ref_len  != '0) && (sel_ref_len  <= REF_MAX_L)  &&
                    (sel_read_len != '0) && (sel_read_len <= READ_MAX_L) &&
                    (sel_read_len <= sel_ref_len);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            wdog          <= '0;
            core_i_valid  <= 1'b0;
            core_seq_ref  <= '0;
            core_seq_read <= '0;
            core_ref_len  <= '0;
            core_read_len <= '0;
            core_i_ready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_status    <= STATUS_OK;
            rsp_score     <= '0;
            rsp_column    <= '0;
            rsp_row       <= '0;
            jobs_done     <= '0;
            stale_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Any result arriving now belongs to a job that already timed out.
                    if (core_i_ready && core_o_valid && stale_cnt != 8'hFF) begin
                        stale_cnt <= stale_cnt + 8'd1;
                    end
                    if (grant_vld) begin
                        rr_ptr       <= ptr_next;
                        rsp_id       <= grant_id;
                        core_i_ready <= 1'b0;
                        if (len_ok) begin
                            core_seq_ref  <= sel_ref;
                            core_seq_read <= sel_read;
                            core_ref_len  <= sel_ref_len;
                            core_read_len <= sel_read_len;
                            core_i_valid  <= 1'b1;
                            state         <= ST_ISSUE;
                        end else begin
                            rsp_status <= STATUS_LEN_ERR;
                            rsp_score  <= '0;
                            rsp_column <= '0;
                            rsp_row    <= '0;
                            rsp_valid  <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end else begin
                        core_i_ready <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    if (core_o_ready) begin
                        core_i_valid <= 1'b0;
                        core_i_ready <= 1'b1;
                        wdog         <= '0;
                        state        <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // A result on the final watchdog cycle still counts as success.
                    if (core_o_valid) begin
                        rsp_status   <= STATUS_OK;
                        rsp_score    <= core_score;
                        rsp_column   <= core_column;
                        rsp_row      <= core_row;
                        rsp_valid    <= 1'b1;
                        core_i_ready <= 1'b0;
                        state        <= ST_RESP;
                    end else if (wdog == WD_LAST) begin
                        rsp_status   <= STATUS_TIMEOUT;
                        rsp_score    <= '0;
                        rsp_column   <= '0;
                        rsp_row      <= '0;
                        rsp_valid    <= 1'b1;
                        core_i_ready <= 1'b0;
                        state        <= ST_RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        jobs_done    <= jobs_done + 16'd1;
                        core_i_ready <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vd_job_scheduler.sv
// Bench for vd_job_scheduler: acts as requesters, VD_core and response sink.
// Expected grants, statuses and counters come from a small rule-level model.
// All sampling and driving happens on the falling clock edge.
module tb_vd_job_scheduler;
    localparam int NUM_REQ   = 2;
    localparam int REF_MAX   = 400;
    localparam int READ_MAX  = 150;
    localparam int SCORE_W   = 16;
    localparam int TMO       = 16;
    localparam int LEN_W     = 9;
    localparam int ID_W      = 1;
    localparam int REF_BITS  = 2 * REF_MAX;
    localparam int READ_BITS = 2 * READ_MAX;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*REF_BITS-1:0]   req_ref;
    logic [NUM_REQ*READ_BITS-1:0]  req_read;
    logic [NUM_REQ*LEN_W-1:0]      req_ref_len;
    logic [NUM_REQ*LEN_W-1:0]      req_read_len;
    logic                          core_o_ready;
    logic                          core_i_valid;
    logic [REF_BITS-1:0]           core_seq_ref;
    logic [READ_BITS-1:0]          core_seq_read;
    logic [LEN_W-1:0]              core_ref_len;
    logic [LEN_W-1:0]              core_read_len;
    logic                          core_i_ready;
    logic                          core_o_valid;
    logic signed [SCORE_W-1:0]     core_score;
    logic [LEN_W-1:0]              core_column;
    logic [7:0]                    core_row;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [1:0]                    rsp_status;
    logic signed [SCORE_W-1:0]     rsp_score;
    logic [LEN_W-1:0]              rsp_column;
    logic [7:0]                    rsp_row;
    logic [15:0]                   jobs_done;
    logic [7:0]                    stale_cnt;

    int total;
    int bad;
    int model_ptr;
    int exp_jobs;
    int exp_stale;

    logic [REF_BITS-1:0]  ref_m  [NUM_REQ];
    logic [READ_BITS-1:0] read_m [NUM_REQ];
    int                   rl_m   [NUM_REQ];
    int                   dl_m   [NUM_REQ];

    vd_job_scheduler #(
        .NUM_REQ(NUM_REQ), .REF_MAX(REF_MAX), .READ_MAX(READ_MAX),
        .SCORE_W(SCORE_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ref(req_ref), .req_read(req_read),
        .req_ref_len(req_ref_len), .req_read_len(req_read_len),
        .core_o_ready(core_o_ready), .core_i_valid(core_i_valid),
        .core_seq_ref(core_seq_ref), .core_seq_read(core_seq_read),
        .core_ref_len(core_ref_len), .core_read_len(core_read_len),
        .core_i_ready(core_i_ready), .core_o_valid(core_o_valid),
        .core_score(core_score), .core_column(core_column), .core_row(core_row),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_status(rsp_status), .rsp_score(rsp_score),
        .rsp_column(rsp_column), .rsp_row(rsp_row),
        .jobs_done(jobs_done), .stale_cnt(stale_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int model_status(input int rl, input int dl);
        if (rl >= 1 && rl <= REF_MAX && dl >= 1 && dl <= READ_MAX && dl <= rl) return 0;
        return 1;
    endfunction

    function automatic int pick_len(input int maxv);
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return maxv;
            3:       return maxv + 1;
            default: return int'($urandom_range(1, maxv));
        endcase
    endfunction

    // ---------------- stimulus drivers (no checking) ----------------
    task automatic load_req(input int i, input int rl, input int dl);
        logic [REF_BITS-1:0]  r;
        logic [READ_BITS-1:0] d;
        r = '0;
        d = '0;
        repeat (REF_BITS / 32) r = {r[REF_BITS-33:0], 32'($urandom())};
        repeat ((READ_BITS + 31) / 32) d = {d[READ_BITS-33:0], 32'($urandom())};
        ref_m[i]  = r;
        read_m[i] = d;
        rl_m[i]   = rl;
        dl_m[i]   = dl;
        req_ref      = {ref_m[1], ref_m[0]};
        req_read     = {read_m[1], read_m[0]};
        req_ref_len  = {LEN_W'(rl_m[1]), LEN_W'(rl_m[0])};
        req_read_len = {LEN_W'(dl_m[1]), LEN_W'(dl_m[0])};
    endtask

    // Plays VD_core: accept after acc_dly cycles, answer res_dly cycles into WAIT.
    task automatic core_serve(input int acc_dly, input int res_dly, input int sc,
                              input int co, input int ro, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (core_i_valid === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            repeat (acc_dly) @(negedge clk);
            core_o_ready = 1'b1;
            @(negedge clk);
            core_o_ready = 1'b0;
            repeat (res_dly) @(negedge clk);
            core_score   = SCORE_W'(sc);
            core_column  = LEN_W'(co);
            core_row     = 8'(ro);
            core_o_valid = 1'b1;
            @(negedge clk);
            core_o_valid = 1'b0;
        end
    endtask

    task automatic rsp_handshake;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_jobs++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b0;
        req_valid = '0; core_o_ready = 1'b0; core_o_valid = 1'b0; rsp_ready = 1'b0;
        core_score = '0; core_column = '0; core_row = '0;
        load_req(0, 1, 1);
        load_req(1, 1, 1);
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        total++; if ({core_i_valid, core_i_ready, rsp_valid} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b want=000", {core_i_valid, core_i_ready, rsp_valid}); end
        total++; if ({rsp_id, rsp_status, rsp_score, rsp_column, rsp_row} !== '0) begin bad++; $display("FAIL reset_rsp_fields got=%h want=0", {rsp_id, rsp_status, rsp_score, rsp_column, rsp_row}); end
        total++; if ({core_ref_len, core_read_len} !== '0 || core_seq_ref !== '0) begin bad++; $display("FAIL reset_core_fields got=%h want=0", {core_ref_len, core_read_len}); end
        total++; if ({jobs_done, stale_cnt} !== 24'd0) begin bad++; $display("FAIL reset_counters got=%h want=0", {jobs_done, stale_cnt}); end
        rst = 1'b1;
        model_ptr = 0; exp_jobs = 0; exp_stale = 0;
        @(negedge clk);
        total++; if (core_i_ready !== 1'b1) begin bad++; $display("FAIL idle_core_i_ready got=%b want=1", core_i_ready); end
    endtask

    task automatic test_single_job;
        int g; bit ok;
        load_req(0, 10, 5);
        req_valid = 2'b01;
        #1;
        g = model_grant(req_valid, model_ptr);
        total++; if (req_ready !== NUM_REQ'(1 << g)) begin bad++; $display("FAIL single_grant got=%b want=%b", req_ready, NUM_REQ'(1 << g)); end
        model_ptr = (g + 1) % NUM_REQ;
        @(negedge clk);
        req_valid = '0;
        total++; if ({core_i_valid, core_i_ready} !== 2'b10) begin bad++; $display("FAIL single_issue got=%b want=10", {core_i_valid, core_i_ready}); end
        total++; if (core_seq_ref !== ref_m[0] || core_seq_read !== read_m[0] || core_ref_len !== 9'd10 || core_read_len !== 9'd5)
            begin bad++; $display("FAIL single_core_job got_len=%0d/%0d want=10/5", core_ref_len, core_read_len); end
        core_serve(8, 10, -37, 9, 4, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_core_wait got=no_issue want=issue"); end
        total++; if ({rsp_valid, rsp_id, rsp_status} !== {1'b1, 1'b0, 2'd0}) begin bad++; $display("FAIL single_rsp_hdr got=%b want=1000", {rsp_valid, rsp_id, rsp_status}); end
        total++; if (rsp_score !== -16'sd37 || rsp_column !== 9'd9 || rsp_row !== 8'd4)
            begin bad++; $display("FAIL single_rsp_data got=%0d/%0d/%0d want=-37/9/4", rsp_score, rsp_column, rsp_row); end
        rsp_handshake();
        total++; if (rsp_valid !== 1'b0 || jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL single_done got=%b/%0d want=0/%0d", rsp_valid, jobs_done, exp_jobs); end
    endtask

    task automatic test_contention;
        int g; bit ok; int sc;
        load_req(0, 50, 30);
        load_req(1, 120, 100);
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1;
            g = model_grant(2'b11, model_ptr);
            total++; if (req_ready !== NUM_REQ'(1 << g)) begin bad++; $display("FAIL contention_grant%0d got=%b want=%b", j, req_ready, NUM_REQ'(1 << g)); end
            model_ptr = (g + 1) % NUM_REQ;
            @(negedge clk);
            total++; if (core_seq_ref !== ref_m[g] || core_seq_read !== read_m[g] || core_ref_len !== 9'(rl_m[g]))
                begin bad++; $display("FAIL contention_route%0d got_len=%0d want=%0d", j, core_ref_len, rl_m[g]); end
            sc = int'($urandom_range(0, 2000)) - 1000;
            core_serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), sc, j, j + 1, ok);
            total++; if (!ok || rsp_valid !== 1'b1 || rsp_id !== ID_W'(g) || rsp_score !== SCORE_W'(sc))
                begin bad++; $display("FAIL contention_rsp%0d got_id=%0d score=%0d want_id=%0d score=%0d", j, rsp_id, rsp_score, g, sc); end
            rsp_handshake();
        end
        req_valid = '0;
        total++; if (jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL contention_jobs got=%0d want=%0d", jobs_done, exp_jobs); end
    endtask

    task automatic test_len_errors;
        int rls [3] = '{0, 200, 10};
        int dls [3] = '{5, 151, 12};
        int g; int st;
        for (int j = 0; j < 3; j++) begin
            load_req(0, rls[j], dls[j]);
            req_valid = 2'b01;
            #1;
            g = model_grant(req_valid, model_ptr);
            st = model_status(rls[j], dls[j]);
            total++; if (req_ready !== NUM_REQ'(1 << g)) begin bad++; $display("FAIL lenerr_grant%0d got=%b want=%b", j, req_ready, NUM_REQ'(1 << g)); end
            model_ptr = (g + 1) % NUM_REQ;
            @(negedge clk);
            req_valid = '0;
            total++; if ({rsp_valid, rsp_status, core_i_valid} !== {1'b1, 2'(st), 1'b0})
                begin bad++; $display("FAIL lenerr_status%0d got=%b want=%b", j, {rsp_valid, rsp_status, core_i_valid}, {1'b1, 2'(st), 1'b0}); end
            total++; if ({rsp_score, rsp_column, rsp_row} !== '0) begin bad++; $display("FAIL lenerr_zero%0d got=%h want=0", j, {rsp_score, rsp_column, rsp_row}); end
            rsp_handshake();
            total++; if (core_i_valid !== 1'b0 || jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL lenerr_after%0d got=%b/%0d want=0/%0d", j, core_i_valid, jobs_done, exp_jobs); end
        end
    endtask

    task automatic test_random_jobs;
        logic [NUM_REQ-1:0] m; int g; int st; int sc; int co; int ro; int rl; int dl; bit ok;
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rl = pick_len(REF_MAX);
                if ($urandom_range(0, 3) == 0 || rl == 0) dl = pick_len(READ_MAX);
                else dl = int'($urandom_range(1, (rl < READ_MAX) ? rl : READ_MAX));
                load_req(i, rl, dl);
            end
            m = NUM_REQ'($urandom_range(1, 3));
            req_valid = m;
            #1;
            g = model_grant(m, model_ptr);
            total++; if (req_ready !== NUM_REQ'(1 << g)) begin bad++; $display("FAIL rand_grant%0d got=%b want=%b", j, req_ready, NUM_REQ'(1 << g)); end
            model_ptr = (g + 1) % NUM_REQ;
            @(negedge clk);
            req_valid = '0;
            st = model_status(rl_m[g], dl_m[g]);
            sc = 0; co = 0; ro = 0;
            if (st == 0) begin
                total++; if (core_i_valid !== 1'b1 || core_seq_ref !== ref_m[g] || core_seq_read !== read_m[g] ||
                             core_ref_len !== 9'(rl_m[g]) || core_read_len !== 9'(dl_m[g]))
                    begin bad++; $display("FAIL rand_issue%0d got=%b len=%0d/%0d want=1 len=%0d/%0d", j, core_i_valid, core_ref_len, core_read_len, rl_m[g], dl_m[g]); end
                sc = int'($urandom_range(0, 65535)) - 32768;
                co = int'($urandom_range(0, 511));
                ro = int'($urandom_range(0, 255));
                core_serve(int'($urandom_range(0, 4)), int'($urandom_range(0, 10)), sc, co, ro, ok);
                if (!ok) begin total++; bad++; $display("FAIL rand_core_wait%0d got=no_issue want=issue", j); end
            end else begin
                total++; if (core_i_valid !== 1'b0) begin bad++; $display("FAIL rand_noissue%0d got=%b want=0", j, core_i_valid); end
            end
            total++; if ({rsp_valid, rsp_id, rsp_status} !== {1'b1, ID_W'(g), 2'(st)})
                begin bad++; $display("FAIL rand_rsp_hdr%0d got=%b want=%b", j, {rsp_valid, rsp_id, rsp_status}, {1'b1, ID_W'(g), 2'(st)}); end
            total++; if ({rsp_score, rsp_column, rsp_row} !== {SCORE_W'(sc), LEN_W'(co), 8'(ro)})
                begin bad++; $display("FAIL rand_rsp_data%0d got=%h want=%h", j, {rsp_score, rsp_column, rsp_row}, {SCORE_W'(sc), LEN_W'(co), 8'(ro)}); end
            rsp_handshake();
            total++; if (jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL rand_jobs%0d got=%0d want=%0d", j, jobs_done, exp_jobs); end
        end
    endtask

    task automatic test_watchdog;
        int cyc; int g;
        load_req(1, 20, 10);
        req_valid = 2'b10;
        #1;
        g = model_grant(req_valid, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        @(negedge clk);
        req_valid = '0;
        core_o_ready = 1'b1;
        @(negedge clk);
        core_o_ready = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc !== TMO) begin bad++; $display("FAIL wdog_latency got=%0d want=%0d", cyc, TMO); end
        total++; if ({rsp_id, rsp_status, rsp_score, rsp_column, rsp_row} !== {ID_W'(g), 2'd2, 33'd0})
            begin bad++; $display("FAIL wdog_rsp got_id=%0d status=%0d want_id=%0d status=2", rsp_id, rsp_status, g); end
        rsp_handshake();
        total++; if (core_i_ready !== 1'b1) begin bad++; $display("FAIL wdog_idle_ready got=%b want=1", core_i_ready); end
        core_o_valid = 1'b1;
        @(negedge clk);
        core_o_valid = 1'b0;
        exp_stale++;
        total++; if (stale_cnt !== 8'(exp_stale) || rsp_valid !== 1'b0) begin bad++; $display("FAIL stale_discard got=%0d/%b want=%0d/0", stale_cnt, rsp_valid, exp_stale); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL stale_no_rsp got=%b/%0d want=0/%0d", rsp_valid, jobs_done, exp_jobs); end

        // Result arriving on the last watchdog cycle must win over the timeout.
        load_req(0, 20, 10);
        req_valid = 2'b01;
        #1;
        g = model_grant(req_valid, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        @(negedge clk);
        req_valid = '0;
        core_o_ready = 1'b1;
        @(negedge clk);
        core_o_ready = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        core_score = 16'sd123; core_column = 9'd77; core_row = 8'd55;
        core_o_valid = 1'b1;
        @(negedge clk);
        core_o_valid = 1'b0;
        total++; if ({rsp_valid, rsp_status, rsp_score, rsp_column, rsp_row} !== {1'b1, 2'd0, 16'sd123, 9'd77, 8'd55})
            begin bad++; $display("FAIL wdog_race got=%b status=%0d score=%0d want=1 status=0 score=123", rsp_valid, rsp_status, rsp_score); end
        rsp_handshake();
    endtask

    task automatic test_backpressure;
        int g; bit stable; int nrsp;
        load_req(0, 30, 20);
        req_valid = 2'b01;
        #1;
        g = model_grant(req_valid, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        @(negedge clk);
        req_valid = '0;
        stable = 1'b1;
        repeat (5) begin
            if (!(core_i_valid === 1'b1 && core_seq_ref === ref_m[0] && core_seq_read === read_m[0] &&
                  core_ref_len === 9'd30 && core_read_len === 9'd20)) stable = 1'b0;
            @(negedge clk);
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_core_hold got=%b want=1", stable); end
        core_o_ready = 1'b1;
        @(negedge clk);
        core_o_ready = 1'b0;
        total++; if (core_i_valid !== 1'b0) begin bad++; $display("FAIL bp_core_drop got=%b want=0", core_i_valid); end
        repeat (3) @(negedge clk);
        core_score = -16'sd500; core_column = 9'd29; core_row = 8'd19;
        core_o_valid = 1'b1;
        @(negedge clk);
        core_o_valid = 1'b0;
        core_score = 16'sd1; core_column = 9'd1; core_row = 8'd1;
        stable = 1'b1;
        repeat (3) begin
            if ({rsp_valid, rsp_id, rsp_status, rsp_score, rsp_column, rsp_row} !==
                {1'b1, 1'b0, 2'd0, -16'sd500, 9'd29, 8'd19}) stable = 1'b0;
            @(negedge clk);
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_rsp_hold got=%b want=1", stable); end
        rsp_handshake();
        nrsp = 0;
        repeat (5) begin
            if (rsp_valid === 1'b1) nrsp++;
            @(negedge clk);
        end
        total++; if (nrsp !== 0 || jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL bp_one_rsp got=%0d/%0d want=0/%0d", nrsp, jobs_done, exp_jobs); end
    endtask

    task automatic test_stale_saturate;
        core_o_valid = 1'b1;
        repeat (300) @(negedge clk);
        core_o_valid = 1'b0;
        exp_stale = (exp_stale + 300 > 255) ? 255 : exp_stale + 300;
        @(negedge clk);
        total++; if (stale_cnt !== 8'(exp_stale) || rsp_valid !== 1'b0) begin bad++; $display("FAIL stale_sat got=%0d/%b want=%0d/0", stale_cnt, rsp_valid, exp_stale); end
    endtask

    task automatic test_reset_in_wait;
        int g; bit ok;
        load_req(0, 40, 40);
        load_req(1, 60, 10);
        req_valid = 2'b01;
        #1;
        g = model_grant(req_valid, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        @(negedge clk);
        req_valid = '0;
        core_o_ready = 1'b1;
        @(negedge clk);
        core_o_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if ({core_i_valid, core_i_ready, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rstwait_valids got=%b want=000", {core_i_valid, core_i_ready, rsp_valid}); end
        total++; if ({jobs_done, stale_cnt} !== 24'd0 || core_seq_ref !== '0) begin bad++; $display("FAIL rstwait_counters got=%h want=0", {jobs_done, stale_cnt}); end
        @(negedge clk);
        rst = 1'b1;
        model_ptr = 0; exp_jobs = 0; exp_stale = 0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstwait_dropped got=%b want=0", rsp_valid); end
        req_valid = 2'b11;
        #1;
        g = model_grant(req_valid, model_ptr);
        total++; if (req_ready !== NUM_REQ'(1 << g)) begin bad++; $display("FAIL rstwait_ptr got=%b want=%b", req_ready, NUM_REQ'(1 << g)); end
        model_ptr = (g + 1) % NUM_REQ;
        @(negedge clk);
        req_valid = '0;
        core_serve(1, 4, 321, 39, 39, ok);
        total++; if (!ok || {rsp_valid, rsp_id, rsp_status, rsp_score} !== {1'b1, ID_W'(g), 2'd0, 16'sd321})
            begin bad++; $display("FAIL rstwait_job got=%b score=%0d want=1 score=321", {rsp_valid, rsp_id, rsp_status}, rsp_score); end
        rsp_handshake();
        total++; if (jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL rstwait_jobs got=%0d want=%0d", jobs_done, exp_jobs); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_job();
        test_contention();
        test_len_errors();
        test_random_jobs();
        test_watchdog();
        test_backpressure();
        test_stale_saturate();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

endmodule
